writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back result selection for the pipelined MIPS core.
//  - Sits directly downstream of the memory stage and captures ReadDataM, ALUOutM and the control fields.
//  - Drives ResultW, WriteRegW and RegWriteW to the register file, and to the hazard unit for forwarding.
//  - Supports stall, flush (bubble insertion) and a retired-instruction counter.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mux2_w.sv | 11 +
 rtl/writeback_stage.sv | 65 ++++++
 tb/tb_writeback_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core constants and the MEM/WB control bundle.
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] wreg;
  } memwb_ctl_t;
endpackage

// File: rtl/mux2_w.sv
// Parameterised 2:1 mux; purely combinational, no backpressure.
module mux2_w #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back result selection and retire counter.
// Latency 1 cycle M->W; StallW holds all state, FlushW loads a bubble (flush wins).
import mips_pkg::*;

module writeback_stage #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [DATA_W-1:0]     ReadDataM,
  input  logic [DATA_W-1:0]     ALUOutM,
  output logic                  ValidW,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [DATA_W-1:0]     ResultW,
  output logic [CNT_W-1:0]      RetireCount
);
  memwb_ctl_t        ctl_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] alu_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ctl_q   <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      cnt_q   <= '0;
    end else if (FlushW) begin
      ctl_q   <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
    end else if (!StallW) begin
      ctl_q.valid    <= ValidM;
      ctl_q.regwrite <= RegWriteM;
      ctl_q.memtoreg <= MemtoRegM;
      ctl_q.wreg     <= WriteRegM;
      rdata_q        <= ReadDataM;
      alu_q          <= ALUOutM;
      if (ValidM)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  mux2_w #(.W(DATA_W)) u_result_mux (
    .d0  (alu_q),
    .d1  (rdata_q),
    .sel (ctl_q.memtoreg),
    .y   (ResultW)
  );

  // Bubbles and writes to $0 never reach the register file or forwarding logic.
  assign RegWriteW   = ctl_q.regwrite & ctl_q.valid & (ctl_q.wreg != REG_ZERO);
  assign WriteRegW   = ctl_q.wreg;
  assign ValidW      = ctl_q.valid;
  assign RetireCount = cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Randomised scoreboard bench for writeback_stage against an architectural model.
module tb_writeback_stage;
  localparam int CW = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        StallW, FlushW, ValidM, RegWriteM, MemtoRegM;
  logic [4:0]  WriteRegM;
  logic [31:0] ReadDataM, ALUOutM;
  logic        ValidW, RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [CW-1:0] RetireCount;

  writeback_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegM(WriteRegM), .ReadDataM(ReadDataM), .ALUOutM(ALUOutM),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .RetireCount(RetireCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    bit          valid;
    bit          rw;
    logic [4:0]  wreg;
    logic [31:0] res;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;          // architectural view of what W presents
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: the W outputs change every edge, so each scheduled entry is checked on the cycle it is due.
  always @(negedge CLK) begin
    while (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) check("stale_entry", 64'(e.due), 64'(cyc));
      else begin
        check("ValidW",      64'(ValidW),      64'(e.valid));
        check("RegWriteW",   64'(RegWriteW),   64'(e.rw));
        check("WriteRegW",   64'(WriteRegW),   64'(e.wreg));
        check("ResultW",     64'(ResultW),     64'(e.res));
        check("RetireCount", 64'(RetireCount), 64'(e.cnt));
      end
    end
  end

  // One M-stage cycle: drive inputs, advance the model, schedule the expectation.
  task automatic step(input bit st, input bit fl, input bit v, input bit rw, input bit m2r,
                      input logic [4:0] wr, input logic [31:0] rd, input logic [31:0] alu);
    @(posedge CLK);
    #1;
    StallW = st; FlushW = fl; ValidM = v; RegWriteM = rw; MemtoRegM = m2r;
    WriteRegM = wr; ReadDataM = rd; ALUOutM = alu;
    if (fl) begin
      m.valid = 0; m.rw = 0; m.wreg = 0; m.res = 0;
    end else if (!st) begin
      m.valid = v;
      m.rw    = rw && v && (wr != 0);
      m.wreg  = wr;
      m.res   = m2r ? rd : alu;
      m.cnt   = CW'((int'(m.cnt) + (v ? 1 : 0)) % (1 << CW));
    end
    m.due = cyc + 1;
    q.push_back(m);
  endtask

  task automatic rand_step(input int stall_pct, input int flush_pct);
    step($urandom_range(99) < stall_pct, $urandom_range(99) < flush_pct,
         $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
         5'($urandom_range(31)), $urandom, $urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge CLK);
      n++;
    end
    @(negedge CLK);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    Reset = 1'b0;
    StallW = 0; FlushW = 0; ValidM = 0; RegWriteM = 0; MemtoRegM = 0;
    WriteRegM = 0; ReadDataM = 0; ALUOutM = 0;
    m = '{default: 0};
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ValidW",      64'(ValidW),      64'd0);
    check("rst_RegWriteW",   64'(RegWriteW),   64'd0);
    check("rst_ResultW",     64'(ResultW),     64'd0);
    check("rst_RetireCount", 64'(RetireCount), 64'd0);
    @(negedge CLK);
    Reset = 1'b1;

    // Load path, both result sources
    step(0, 0, 1, 1, 1, 5'd8, 32'hDEADBEEF, 32'h10);
    step(0, 0, 1, 1, 0, 5'd8, 32'hDEADBEEF, 32'h10);
    // Write to $0 suppressed, still retires
    step(0, 0, 1, 1, 0, 5'd0, 32'h1234, 32'h5678);
    step(0, 0, 1, 1, 1, 5'd3, 32'hCAFE0001, 32'h44);
    // Stall with fresh inputs, then flush overriding stall
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 5'd9 + 5'(i), $urandom, $urandom);
    step(1, 1, 1, 1, 1, 5'd7, 32'hAAAA, 32'hBBBB);
    // Bubble with RegWriteM high
    step(0, 0, 0, 1, 1, 5'd5, 32'h1111, 32'h2222);
    // Enough valid loads to wrap the counter
    for (int i = 0; i < 17; i++) step(0, 0, 1, 1, 0, 5'd1, 32'h0, 32'(i));
    // Random traffic
    for (int i = 0; i < 300; i++) rand_step(15, 8);

    // Mid-stream asynchronous reset with a live instruction in W
    step(0, 0, 1, 1, 0, 5'd12, 32'h0, 32'h77);
    drain();
    check("pre_rst_ValidW", 64'(ValidW), 64'd1);
    Reset = 1'b0;
    #1;
    check("async_ValidW",      64'(ValidW),      64'd0);
    check("async_RegWriteW",   64'(RegWriteW),   64'd0);
    check("async_WriteRegW",   64'(WriteRegW),   64'd0);
    check("async_ResultW",     64'(ResultW),     64'd0);
    check("async_RetireCount", 64'(RetireCount), 64'd0);
    StallW = 0; FlushW = 0; ValidM = 0; RegWriteM = 0; MemtoRegM = 0;
    WriteRegM = 0; ReadDataM = 0; ALUOutM = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    m = '{default: 0};
    @(posedge CLK);
    #1;
    check("post_rst_ValidW",      64'(ValidW),      64'd0);
    check("post_rst_RegWriteW",   64'(RegWriteW),   64'd0);
    check("post_rst_RetireCount", 64'(RetireCount), 64'd0);

    for (int i = 0; i < 100; i++) rand_step(20, 10);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
